// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute stage.
//   Opcode encodings, FSM state encoding, flag bit positions and the
//   number of shift-add steps used by the iterative multiplier.
//   Optional multiplier is controlled by the EXEC_MUL_EN macro (see exec_unit).
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_N    = 2;
  localparam int MUL_STEPS = 16;

  // Assemble the {N,C,Z} flag vector from its individual bits.
  function automatic logic [2:0] pack_flags(input logic n, input logic c, input logic z);
    logic [2:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// exec_unit_if: request / write-back bundle between the issuing logic,
// the execute stage and the register file write port.
//   Request : Start, Opcode, Dest, Op_a, Op_b   (master -> slave)
//   Status  : Busy, Done, Flags                 (slave -> master)
//   Write   : Write_enable, Wreg, Data_out      (slave -> master)
interface exec_unit_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  Start;
  logic [2:0]            Opcode;
  logic [REG_ADDR_W-1:0] Dest;
  logic [WIDTH-1:0]      Op_a;
  logic [WIDTH-1:0]      Op_b;
  logic                  Busy;
  logic                  Done;
  logic                  Write_enable;
  logic [REG_ADDR_W-1:0] Wreg;
  logic [WIDTH-1:0]      Data_out;
  logic [2:0]            Flags;

  modport master (
    output Start, Opcode, Dest, Op_a, Op_b,
    input  Busy, Done, Write_enable, Wreg, Data_out, Flags
  );

  modport slave (
    input  Start, Opcode, Dest, Op_a, Op_b,
    output Busy, Done, Write_enable, Wreg, Data_out, Flags
  );
endinterface

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: iterative shift-add multiplier, one partial product per step.
//   Clock, Reset_n : clock and synchronous active-low reset
//   load_i         : capture a_i/b_i, clear the accumulator and step count
//   step_i         : perform one shift-add step (ignored once all steps done)
//   a_i, b_i       : operands
//   last_o         : the step taken this cycle is the final one
//   product_o      : full 2*WIDTH product, valid after MUL_STEPS steps
module exec_mul_seq
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Each step adds the shifted multiplicand when the current multiplier LSB
  // is set, then shifts both so the next bit lines up with the next weight.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      count_d  = '0;
    end else if (step_i && (count_q < CNT_W'(MUL_STEPS))) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign last_o    = (count_q == CNT_W'(MUL_STEPS - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execute stage feeding the register file write port.
//   Clock, Reset_n : clock and synchronous active-low reset
//   bus (slave)    : Start/Opcode/Dest/Op_a/Op_b request; Busy/Done status;
//                    Write_enable/Wreg/Data_out write-back; Flags {N,C,Z}
// ALU ops write back one cycle after Start; MUL (when EXEC_MUL_EN is defined)
// spends 16 cycles in the iterative multiplier. Without EXEC_MUL_EN, opcode
// 111 is acknowledged with Done but writes nothing and leaves Flags alone.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) (
  input logic        Clock,
  input logic        Reset_n,
  exec_unit_if.slave bus
);

  state_t                state_q, state_d;
  logic [2:0]            opcode_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WIDTH-1:0]      result_q;
  logic                  carry_q;
  logic [2:0]            flags_q;

  logic                  startAccept;
  logic [WIDTH:0]        sum;
  logic [2*WIDTH-1:0]    shl;
  logic [2*WIDTH-1:0]    shr;
  logic [WIDTH-1:0]      aluResult;
  logic                  aluCarry;
  logic [WIDTH-1:0]      wbData;
  logic                  wbCarry;
  logic                  wbWrite;
  logic [2:0]            wbFlags;
  logic                  mulDone;

  assign startAccept = (state_q == ST_IDLE) && bus.Start;

  // Shifts are done in a double-width field so the last bit shifted out lands
  // at a fixed position (bit WIDTH for SHL, bit WIDTH-1 for SHR); a shift of
  // zero naturally leaves that position clear.
  assign sum = {1'b0, bus.Op_a} + {1'b0, bus.Op_b};
  assign shl = {{WIDTH{1'b0}}, bus.Op_a} << bus.Op_b[3:0];
  assign shr = {bus.Op_a, {WIDTH{1'b0}}} >> bus.Op_b[3:0];

  // Single-cycle ALU evaluated on the request operands; its result and carry
  // are captured when Start is accepted.
  always_comb begin
    aluResult = '0;
    aluCarry  = 1'b0;
    case (bus.Opcode)
      OP_ADD: begin
        aluResult = sum[WIDTH-1:0];
        aluCarry  = sum[WIDTH];
      end
      OP_SUB: begin
        aluResult = bus.Op_a - bus.Op_b;
        aluCarry  = (bus.Op_a < bus.Op_b);
      end
      OP_AND: aluResult = bus.Op_a & bus.Op_b;
      OP_OR:  aluResult = bus.Op_a | bus.Op_b;
      OP_XOR: aluResult = bus.Op_a ^ bus.Op_b;
      OP_SHL: begin
        aluResult = shl[WIDTH-1:0];
        aluCarry  = shl[WIDTH];
      end
      OP_SHR: begin
        aluResult = shr[2*WIDTH-1:WIDTH];
        aluCarry  = shr[WIDTH-1];
      end
      default: begin
        aluResult = '0;
        aluCarry  = 1'b0;
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] product;
  logic               mulLast;

  exec_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .load_i   (startAccept && (bus.Opcode == OP_MUL)),
    .step_i   (state_q == ST_MUL),
    .a_i      (bus.Op_a),
    .b_i      (bus.Op_b),
    .last_o   (mulLast),
    .product_o(product)
  );

  // The final multiplier step and the move to WB share an edge, so the WB
  // cycle reads the product register directly.
  always_comb begin
    wbWrite = 1'b1;
    mulDone = mulLast;
    wbData  = result_q;
    wbCarry = carry_q;
    if (opcode_q == OP_MUL) begin
      wbData  = product[WIDTH-1:0];
      wbCarry = |product[2*WIDTH-1:WIDTH];
    end
  end
`else
  // No multiplier: opcode 111 is treated as an acknowledged no-op.
  always_comb begin
    wbWrite = (opcode_q != OP_MUL);
    mulDone = 1'b0;
    wbData  = result_q;
    wbCarry = carry_q;
  end
`endif

  // Flags shown during WB are the fresh ones; they are committed to flags_q
  // as WB ends and then held until the next writing op.
  always_comb begin
    wbFlags = flags_q;
    if (wbWrite) begin
      wbFlags = pack_flags(wbData[WIDTH-1], wbCarry, (wbData == '0));
    end
  end

  // Next-state and output decode; requests outside IDLE are simply dropped.
  always_comb begin
    state_d          = state_q;
    bus.Busy         = 1'b0;
    bus.Done         = 1'b0;
    bus.Write_enable = 1'b0;
    bus.Wreg         = dest_q;
    bus.Data_out     = '0;
    bus.Flags        = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
`ifdef EXEC_MUL_EN
          state_d = (bus.Opcode == OP_MUL) ? ST_MUL : ST_WB;
`else
          state_d = ST_WB;
`endif
        end
      end
`ifdef EXEC_MUL_EN
      ST_MUL: begin
        bus.Busy = 1'b1;
        if (mulDone) begin
          state_d = ST_WB;
        end
      end
`endif
      ST_WB: begin
        bus.Busy         = 1'b1;
        bus.Done         = 1'b1;
        bus.Write_enable = wbWrite;
        bus.Data_out     = wbWrite ? wbData : '0;
        bus.Flags        = wbFlags;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request capture and flag registers; reset abandons any op in flight.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      dest_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (startAccept) begin
        opcode_q <= bus.Opcode;
        dest_q   <= bus.Dest;
        result_q <= aluResult;
        carry_q  <= aluCarry;
      end
      if (state_q == ST_WB) begin
        flags_q <= wbFlags;
      end
    end
  end

endmodule
